// File: rtl/fm_ddr_writeback_packer.sv
// fm_ddr_writeback_packer: packs conv beats LSB-first into DDR words with burst
// last framing and an end-of-layer flush that zero-pads the residual word.
module fm_ddr_writeback_packer #(
    parameter int IN_WIDTH  = 144,
    parameter int OUT_WIDTH = 256,
    parameter int BURST_LEN = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  Conv_data_in,
    input  logic                 Conv_valid_in,
    output logic                 Conv_ready_out,
    input  logic                 flush_in,
    output logic [OUT_WIDTH-1:0] DDR_data_out,
    output logic                 DDR_valid_out,
    input  logic                 DDR_ready_in,
    output logic                 DDR_last_out,
    output logic                 flush_done,
    output logic [CNT_WIDTH-1:0] word_cnt
);
    localparam int AW  = OUT_WIDTH + IN_WIDTH;
    localparam int FW  = $clog2(AW + 1);
    localparam int FW1 = FW + 1;
    localparam int BW  = $clog2(BURST_LEN + 1);
    typedef enum logic {RUN, FLUSH} state_t;
    state_t state, state_next;
    logic [AW-1:0] acc, acc_next;
    logic [FW-1:0] fill, fill_next, base;
    logic [FW1-1:0] need;
    logic [BW-1:0] burst, burst_inc;
    logic free, pop, resid, push, load, blast, load_last, flushing, force_last, hs;
    always_comb begin
        free           = !DDR_valid_out || DDR_ready_in;
        pop            = fill >= FW'(OUT_WIDTH) && free;
        resid          = state == FLUSH && fill != '0 && fill < FW'(OUT_WIDTH) && free;
        need           = {1'b0, fill} + FW1'(IN_WIDTH) - (pop ? FW1'(OUT_WIDTH) : '0);
        Conv_ready_out = state == RUN && need <= FW1'(AW);
        push           = Conv_valid_in && Conv_ready_out;
        base           = pop ? fill - FW'(OUT_WIDTH) : resid ? '0 : fill;
        // bits above fill are always zero, so OR-ing the beat in and popping the low word pads for free
        acc_next       = (pop ? acc >> OUT_WIDTH : resid ? '0 : acc) | (push ? AW'(Conv_data_in) << base : '0);
        fill_next      = base + (push ? FW'(IN_WIDTH) : '0);
        load           = pop || resid;
        flushing       = state == FLUSH || flush_in;
        burst_inc      = burst + BW'(1);
        blast          = burst_inc == BW'(BURST_LEN);
        load_last      = blast || (flushing && fill_next == '0);
        force_last     = flushing && fill == '0 && !push && DDR_valid_out && !DDR_ready_in;
        hs             = DDR_valid_out && DDR_ready_in;
        flush_done     = state == FLUSH && fill == '0 && !DDR_valid_out;
        state_next     = state == RUN ? (flush_in ? FLUSH : RUN) : (flush_done ? RUN : FLUSH);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            acc           <= '0;
            fill          <= '0;
            burst         <= '0;
            word_cnt      <= '0;
            DDR_data_out  <= '0;
            DDR_valid_out <= 1'b0;
            DDR_last_out  <= 1'b0;
        end else begin
            state         <= state_next;
            acc           <= acc_next;
            fill          <= fill_next;
            DDR_data_out  <= load ? acc[OUT_WIDTH-1:0] : DDR_data_out;
            DDR_valid_out <= load || (DDR_valid_out && !DDR_ready_in);
            DDR_last_out  <= load ? load_last : hs ? 1'b0 : DDR_last_out || force_last;
            burst         <= flush_done ? '0 : load ? (blast ? '0 : burst_inc) : burst;
            word_cnt      <= flush_done ? '0 : word_cnt + CNT_WIDTH'(hs);
        end
    end
endmodule
